alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/alu_arbiter_if.sv | 37 +++
 rtl/alu_arbiter_rr_pick.sv | 27 ++
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, ALU opcodes and the ALU arbiter state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side and ALU-side bus of the shared-ALU arbiter.
interface alu_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    import cpu_types_pkg::*;

    logic [NREQ-1:0] req;
    aluop_t          op [NREQ];
    word_t           a  [NREQ];
    word_t           b  [NREQ];
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    word_t           result;
    logic            n_out;
    logic            z_out;
    logic            v_out;

    aluop_t          alu_op_o;
    word_t           port_a_o;
    word_t           port_b_o;
    word_t           port_o_i;
    logic            n_i;
    logic            z_i;
    logic            v_i;

    // Requesters plus the ALU itself sit on the master side.
    modport master (
        output req, op, a, b, port_o_i, n_i, z_i, v_i,
        input  gnt, done, result, n_out, z_out, v_out, alu_op_o, port_a_o, port_b_o
    );

    modport slave (
        input  req, op, a, b, port_o_i, n_i, z_i, v_i,
        output gnt, done, result, n_out, z_out, v_out, alu_op_o, port_a_o, port_b_o
    );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational winner select: first set request searching upward from ptr, wrapping.
module rr_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  winner
);

    int unsigned pos;
    logic        found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = (32'(ptr) + i) % NREQ;
            if (!found && req[IDX_W'(pos)]) begin
                winner[IDX_W'(pos)] = 1'b1;
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: grant, execute, respond (3 cycles per op).
// ALU_ARB_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    alu_arbiter_if.slave  bus
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state;
    logic [NREQ-1:0]  winner;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] owner;
    aluop_t           op_q;
    word_t            a_q;
    word_t            b_q;
    logic             any_req;

    assign any_req = |bus.req;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner[IDX_W'(i)]) win_idx = IDX_W'(i);
        end
    end

    // Grant marks the capture edge, so it is only visible while idle and out of reset.
    assign bus.gnt = (state == IDLE && nRST) ? winner : '0;

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr <= '0;
        end else if (state == IDLE && any_req) begin
            ptr <= (32'(win_idx) == NREQ - 1) ? '0 : win_idx + IDX_W'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    // The ALU only ever sees latched operands.
    assign bus.alu_op_o = op_q;
    assign bus.port_a_o = a_q;
    assign bus.port_b_o = b_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            bus.done   <= '0;
            bus.result <= '0;
            bus.n_out  <= 1'b0;
            bus.z_out  <= 1'b0;
            bus.v_out  <= 1'b0;
            op_q       <= ALU_ADD;
            a_q        <= '0;
            b_q        <= '0;
            owner      <= '0;
        end else begin
            bus.done <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        op_q  <= bus.op[win_idx];
                        a_q   <= bus.a[win_idx];
                        b_q   <= bus.b[win_idx];
                        owner <= win_idx;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    bus.result <= bus.port_o_i;
                    bus.n_out  <= bus.n_i;
                    bus.z_out  <= bus.z_i;
                    bus.v_out  <= bus.v_i;
                    bus.done   <= NREQ'(1) << owner;
                    state      <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level model checked every cycle.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned NREQ = 2;

    logic CLK = 1'b0;
    logic nRST;
    int   checks = 0;
    int   passed = 0;

    always #5 CLK = ~CLK;

    alu_arbiter_if #(.NREQ(NREQ)) bus ();

    alu_arbiter #(.NREQ(NREQ)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    function automatic word_t alu_res(input aluop_t o, input word_t x, input word_t y);
        case (o)
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            ALU_XOR:  return x ^ y;
            ALU_SLL:  return x << y[4:0];
            ALU_SRL:  return x >> y[4:0];
            ALU_SRA:  return word_t'($signed(x) >>> y[4:0]);
            ALU_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
            default:  return '0;
        endcase
    endfunction

    function automatic logic alu_ovf(input aluop_t o, input word_t x, input word_t y);
        word_t r;
        r = alu_res(o, x, y);
        if (o == ALU_ADD) return (x[31] == y[31]) && (r[31] != x[31]);
        if (o == ALU_SUB) return (x[31] != y[31]) && (r[31] != x[31]);
        return 1'b0;
    endfunction

    // Behavioural ALU on the arbiter's ALU port.
    always_comb begin
        bus.port_o_i = alu_res(bus.alu_op_o, bus.port_a_o, bus.port_b_o);
        bus.n_i      = bus.port_o_i[31];
        bus.z_i      = (bus.port_o_i == '0);
        bus.v_i      = alu_ovf(bus.alu_op_o, bus.port_a_o, bus.port_b_o);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // First requester at or after start, wrapping; start is always 0 for fixed priority.
    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(start + i) % NREQ]) return (start + i) % NREQ;
        end
        return -1;
    endfunction

    // Model: one op may start only 3+ cycles after the last start; done and result 2 cycles later.
    int              cyc;
    int              last_gnt;
    int              m_owner;
    int              rr_next;
    aluop_t          m_op;
    word_t           m_a, m_b, m_res;
    logic            m_n, m_z, m_v;

    always @(negedge CLK) begin
        logic [NREQ-1:0] exp_gnt, exp_done;
        int w;
        if (!nRST) begin
            chk("rst_gnt", bus.gnt, '0);
            chk("rst_done", bus.done, '0);
            chk("rst_result", bus.result, '0);
            chk("rst_flags", {bus.n_out, bus.z_out, bus.v_out}, 3'b000);
            chk("rst_ports", {bus.alu_op_o, bus.port_a_o, bus.port_b_o}, '0);
            cyc = 0; last_gnt = -100; m_owner = 0; rr_next = 0;
            m_op = ALU_ADD; m_a = '0; m_b = '0; m_res = '0;
            m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
        end else begin
            exp_gnt  = '0;
            exp_done = '0;
            w        = -1;
            if (cyc - last_gnt >= 3 && |bus.req) begin
`ifdef ALU_ARB_RR_EN
                w = pick(bus.req, rr_next);
`else
                w = pick(bus.req, 0);
`endif
                exp_gnt[w] = 1'b1;
            end
            if (cyc == last_gnt + 2) begin
                exp_done[m_owner] = 1'b1;
                m_res = alu_res(m_op, m_a, m_b);
                m_n   = m_res[31];
                m_z   = (m_res == '0);
                m_v   = alu_ovf(m_op, m_a, m_b);
            end
            chk("gnt", bus.gnt, exp_gnt);
            chk("done", bus.done, exp_done);
            chk("result", bus.result, m_res);
            chk("flags", {bus.n_out, bus.z_out, bus.v_out}, {m_n, m_z, m_v});
            chk("alu_ports", {bus.alu_op_o, bus.port_a_o, bus.port_b_o}, {m_op, m_a, m_b});
            if (w >= 0) begin
                m_op = bus.op[w]; m_a = bus.a[w]; m_b = bus.b[w];
                m_owner = w; last_gnt = cyc; rr_next = (w + 1) % NREQ;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input aluop_t o, input word_t x, input word_t y);
        bus.op[i]  = o;
        bus.a[i]   = x;
        bus.b[i]   = y;
        bus.req[i] = 1'b1;
    endtask

    int order[$];
    int exp_order[6];
    int cnt0, cnt1;

    initial begin
        nRST    = 1'b0;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.op[i] = ALU_ADD; bus.a[i] = '0; bus.b[i] = '0;
        end
        repeat (3) step();
        nRST = 1'b1;
        step();

        // Signed overflow on ADD.
        set_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        #1 chk("t1_gnt", bus.gnt, 2'b01);
        step();
        chk("t1_exec_done", bus.done, 2'b00);
        step();
        chk("t1_done", bus.done, 2'b01);
        chk("t1_result", bus.result, 32'h8000_0000);
        chk("t1_nzv", {bus.n_out, bus.z_out, bus.v_out}, 3'b101);
        bus.req[0] = 1'b0;
        step();

        // Zero result from requester 1.
        set_req(1, ALU_SUB, 32'd5, 32'd5);
        #1 chk("t2_gnt", bus.gnt, 2'b10);
        step();
        step();
        chk("t2_done", bus.done, 2'b10);
        chk("t2_result", bus.result, 32'h0);
        chk("t2_nzv", {bus.n_out, bus.z_out, bus.v_out}, 3'b010);
        bus.req[1] = 1'b0;
        step();

        // Both requesters contend for three ops each.
        set_req(0, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        set_req(1, ALU_SLL, 32'h1, 32'd4);
        cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 40 && (cnt0 < 3 || cnt1 < 3); c++) begin
            #1;
            if (bus.gnt[0]) order.push_back(0);
            if (bus.gnt[1]) order.push_back(1);
            if (bus.done[0]) cnt0++;
            if (bus.done[1]) cnt1++;
            step();
            if (cnt0 >= 3) bus.req[0] = 1'b0;
            if (cnt1 >= 3) bus.req[1] = 1'b0;
        end
`ifdef ALU_ARB_RR_EN
        exp_order = '{0, 1, 0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 1, 1, 1};
`endif
        chk("t3_ops", {32'(cnt0), 32'(cnt1)}, {32'd3, 32'd3});
        chk("t3_len", 64'(order.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t3_order%0d", i), (i < order.size()) ? 64'(order[i]) : 64'hFF,
                64'(exp_order[i]));
        end
        bus.req = '0;
        step();

        // Requester drops req right after its grant.
        set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'h1);
        #1 chk("t4_gnt", bus.gnt, 2'b10);
        step();
        bus.req[1] = 1'b0;
        step();
        chk("t4_done", bus.done, 2'b10);
        chk("t4_result", bus.result, 32'h1);
        step();

        // Operands change during EXEC; latched values must stand.
        set_req(0, ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        step();
        bus.op[0] = ALU_SUB; bus.a[0] = 32'h1234_5678; bus.b[0] = 32'h0;
        #1 chk("t5_ports", {bus.alu_op_o, bus.port_a_o, bus.port_b_o},
               {ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0});
        step();
        chk("t5_done", bus.done, 2'b01);
        chk("t5_result", bus.result, 32'hFF00_FF00);
        bus.req[0] = 1'b0;
        step();

        // Reset during EXEC kills the op; the requester reissues.
        set_req(0, ALU_ADD, 32'd10, 32'd20);
        step();
        #1 nRST = 1'b0;
        #1 chk("t6_rst_now", {bus.done, bus.result, bus.port_a_o}, '0);
        step();
        nRST = 1'b1;
        #1 chk("t6_regnt", bus.gnt, 2'b01);
        step();
        step();
        chk("t6_done", bus.done, 2'b01);
        chk("t6_result", bus.result, 32'd30);
        bus.req[0] = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
